// File: rtl/dma_pkg.sv
// Shared types for the ROM-to-RAM DMA controller: FSM states and the latched descriptor.
// Descriptor field widths follow the default DEPTH; keep dma_ctrl's DEPTH in step with DMA_DEPTH.
package dma_pkg;
  localparam int DMA_DATA_WIDTH = 8;
  localparam int DMA_DEPTH      = 16;
  localparam int DMA_NUM_CH     = 2;
  localparam int DMA_ADDR_WIDTH = $clog2(DMA_DEPTH);
  localparam int DMA_LEN_WIDTH  = DMA_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } dma_state_e;

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] src;
    logic [DMA_ADDR_WIDTH-1:0] dst;
    logic [DMA_LEN_WIDTH-1:0]  len;
  } dma_desc_t;
endpackage

// File: rtl/dma_ctrl_if.sv
// Requester, completion and ROM/RAM signals of dma_ctrl; master is the controller side.
interface dma_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 2
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam int IDX_WIDTH  = $clog2(NUM_CH);

  logic [NUM_CH-1:0]                 req;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] src_addr;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] dst_addr;
  logic [NUM_CH-1:0][LEN_WIDTH-1:0]  len;
  logic [NUM_CH-1:0]                 done;
  logic                              busy;
  logic [IDX_WIDTH-1:0]              grant_id;
  logic                              rom_en;
  logic [ADDR_WIDTH-1:0]             rom_addr;
  logic [DATA_WIDTH-1:0]             rom_data;
  logic                              ram_wea;
  logic [ADDR_WIDTH-1:0]             ram_addr;
  logic [DATA_WIDTH-1:0]             ram_data;

  modport master (
    input  req, src_addr, dst_addr, len, rom_data,
    output done, busy, grant_id, rom_en, rom_addr, ram_wea, ram_addr, ram_data
  );

  modport slave (
    output req, src_addr, dst_addr, len, rom_data,
    input  done, busy, grant_id, rom_en, rom_addr, ram_wea, ram_addr, ram_data
  );
endinterface

// File: rtl/dma_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (last_i+1) mod NUM_CH.
module rr_arbiter #(
  parameter  int NUM_CH    = 2,
  localparam int IDX_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [IDX_WIDTH-1:0] last_i,
  output logic                 grant_vld_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o
);
  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    // Scan farthest-to-nearest so the nearest requester after last_i wins.
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = IDX_WIDTH'((int'(last_i) + off) % NUM_CH);
      if (req_i[cand]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = cand;
      end
    end
  end
endmodule

// File: rtl/dma_ctrl.sv
// Round-robin multi-channel ROM-to-RAM block copier; one read per RUN cycle, writes trail by one.
// len=N finishes with done N+2 cycles after the grant edge (1 cycle for len=0).
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int DEPTH      = DMA_DEPTH,
  parameter int NUM_CH     = DMA_NUM_CH
) (
  input  logic       clk,
  input  logic       reset,
  dma_ctrl_if.master bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam int IDX_WIDTH  = $clog2(NUM_CH);

  dma_state_e             state_q, state_d;
  dma_desc_t              desc_q, desc_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic [LEN_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   rd_vld_q;
  logic                   arb_vld;
  logic [IDX_WIDTH-1:0]   arb_idx;
  logic                   rom_en_w;
  logic [ADDR_WIDTH-1:0]  rom_addr_w;
  logic [NUM_CH-1:0]      done_w;
  logic [DATA_WIDTH-1:0]  wr_dat;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i       (bus.req),
    .last_i      (last_q),
    .grant_vld_o (arb_vld),
    .grant_idx_o (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      desc_q    <= '0;
      grant_q   <= '0;
      last_q    <= IDX_WIDTH'(NUM_CH - 1);
      rd_cnt_q  <= '0;
      wr_addr_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_vld_q  <= rom_en_w;
    end
  end

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rd_cnt_d   = rd_cnt_q;
    wr_addr_d  = wr_addr_q;
    rom_en_w   = 1'b0;
    rom_addr_w = '0;
    done_w     = '0;

    if (rd_vld_q) begin
      wr_addr_d = ADDR_WIDTH'((int'(wr_addr_q) + 1) % DEPTH);
    end

    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d     = arb_idx;
          last_d      = arb_idx;
          desc_d.src  = bus.src_addr[arb_idx];
          desc_d.dst  = bus.dst_addr[arb_idx];
          desc_d.len  = bus.len[arb_idx];
          rd_cnt_d    = '0;
          state_d     = (bus.len[arb_idx] != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        rom_en_w   = 1'b1;
        rom_addr_w = ADDR_WIDTH'((int'(desc_q.src) + int'(rd_cnt_q)) % DEPTH);
        // First RUN cycle: no write is pending yet, so seed the write pointer.
        if (rd_cnt_q == '0) begin
          wr_addr_d = desc_q.dst;
        end
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_d == desc_q.len) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        done_w[grant_q] = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_dat       = bus.rom_data;
  assign bus.ram_data = wr_dat;
  assign bus.ram_wea  = rd_vld_q;
  assign bus.ram_addr = wr_addr_q;
  assign bus.rom_en   = rom_en_w;
  assign bus.rom_addr = rom_addr_w;
  assign bus.done     = done_w;
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: a transaction-level round-robin model fills expectation queues,
// a negedge monitor pops and compares every grant, ROM read, RAM write and done pulse.
module tb_dma_ctrl;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int LW     = 5;

  typedef struct {
    int ch;
    int lat;
  } gnt_t;

  typedef struct {
    int addr;
    int data;
    int off;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

  dma_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  gnt_t gq[$];
  acc_t rq[$];
  acc_t wq[$];

  logic [7:0] rom [DEPTH];
  logic [7:0] ram [DEPTH]     = '{default: 8'h00};
  logic [7:0] exp_ram [DEPTH] = '{default: 8'h00};

  int d_src [NUM_CH];
  int d_dst [NUM_CH];
  int d_len [NUM_CH];
  int d_rem [NUM_CH];
  int m_last = NUM_CH - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous ROM and write-only RAM behind the controller.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    if (bus.ram_wea) ram[bus.ram_addr] <= bus.ram_data;
  end

  // Monitor: sampled on the falling edge, decoupled from stimulus.
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_busy = 1'b0;
  logic active = 1'b0;
  logic busy_chk = 1'b0;
  gnt_t cur;
  always @(negedge clk) begin
    gnt_t g;
    acc_t a;
    if (reset) begin
      prev_busy = 1'b0;
      active    = 1'b0;
      busy_chk  = 1'b0;
    end else begin
      cyc++;
      if (bus.busy && !prev_busy) begin
        chk("grant_expected", 32'(gq.size() > 0), 1);
        if (gq.size() > 0) begin
          g = gq.pop_front();
          chk("grant_id", 32'(bus.grant_id), g.ch);
          cur      = g;
          rise_cyc = cyc;
          active   = 1'b1;
        end
      end
      if (bus.rom_en) begin
        chk("rd_expected", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          a = rq.pop_front();
          chk("rd_addr", 32'(bus.rom_addr), a.addr);
          chk("rd_cycle", cyc - rise_cyc, a.off);
        end
      end
      if (bus.ram_wea) begin
        chk("wr_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          a = wq.pop_front();
          chk("wr_addr", 32'(bus.ram_addr), a.addr);
          chk("wr_data", 32'(bus.ram_data), a.data);
          chk("wr_cycle", cyc - rise_cyc, a.off);
        end
      end
      if (bus.done != '0) begin
        chk("done_expected", 32'(active), 1);
        if (active) begin
          chk("done_vec", 32'(bus.done), 32'(1) << cur.ch);
          chk("done_lat", cyc - rise_cyc + 1, cur.lat);
          active   = 1'b0;
          busy_chk = 1'b1;
        end
      end else if (busy_chk) begin
        chk("busy_after_done", 32'(bus.busy), 0);
        busy_chk = 1'b0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
    chk({tag, "_rom_en"}, 32'(bus.rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_ram_wea"}, 32'(bus.ram_wea), 0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
  endtask

  task automatic check_drained();
    chk("grant_q_empty", gq.size(), 0);
    chk("rd_q_empty", rq.size(), 0);
    chk("wr_q_empty", wq.size(), 0);
  endtask

  // One round: channels with d_rem>0 request together; each holds req until its d_rem-th done.
  task automatic run_round();
    int rem_m [NUM_CH];
    int drv_rem [NUM_CH];
    int left;
    int c;
    int budget;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rem_m[ch]   = d_rem[ch];
      drv_rem[ch] = d_rem[ch];
      bus.src_addr[ch] = AW'(d_src[ch]);
      bus.dst_addr[ch] = AW'(d_dst[ch]);
      bus.len[ch]      = LW'(d_len[ch]);
    end
    left = 0;
    for (int ch = 0; ch < NUM_CH; ch++) left += rem_m[ch];
    while (left > 0) begin
      c = m_last;
      do c = (c + 1) % NUM_CH; while (rem_m[c] == 0);
      gq.push_back('{ch: c, lat: (d_len[c] == 0) ? 1 : d_len[c] + 2});
      for (int k = 1; k <= d_len[c]; k++) begin
        int ra;
        int wa;
        ra = (d_src[c] + k - 1) % DEPTH;
        wa = (d_dst[c] + k - 1) % DEPTH;
        rq.push_back('{addr: ra, data: 0, off: k - 1});
        wq.push_back('{addr: wa, data: int'(rom[ra]), off: k});
        exp_ram[wa] = rom[ra];
      end
      rem_m[c]--;
      m_last = c;
      left--;
    end
    for (int ch = 0; ch < NUM_CH; ch++) bus.req[ch] = (drv_rem[ch] > 0);
    budget = 0;
    while (budget < 5000) begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.done[ch] && drv_rem[ch] > 0) begin
          drv_rem[ch]--;
          if (drv_rem[ch] == 0) bus.req[ch] = 1'b0;
        end
      end
      left = 0;
      for (int ch = 0; ch < NUM_CH; ch++) left += drv_rem[ch];
      if (left == 0 && !bus.busy) break;
      budget++;
    end
    chk("round_in_time", 32'(budget < 5000), 1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_drained();
    for (int i = 0; i < DEPTH; i++) chk($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  // Abort a len=8 transfer in its second RUN cycle; only the first write lands.
  task automatic reset_mid_run();
    int budget;
    bus.src_addr[0] = AW'(3);
    bus.dst_addr[0] = AW'(9);
    bus.len[0]      = LW'(8);
    gq.push_back('{ch: 0, lat: 10});
    rq.push_back('{addr: 3, data: 0, off: 0});
    rq.push_back('{addr: 4, data: 0, off: 1});
    wq.push_back('{addr: 9, data: int'(rom[3]), off: 1});
    exp_ram[9] = rom[3];
    bus.req[0] = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.busy && budget < 20);
    chk("rst_run_started", 32'(bus.busy), 1);
    @(negedge clk);
    #1;
    reset      = 1'b1;
    bus.req[0] = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    reset  = 1'b0;
    m_last = NUM_CH - 1;
    repeat (12) @(negedge clk);
    check_drained();
    chk("ram[9]_after_abort", 32'(ram[9]), 32'(exp_ram[9]));
    chk("ram[10]_untouched", 32'(ram[10]), 32'(exp_ram[10]));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'(i + 8'h10);
    reset        = 1'b1;
    bus.req      = '0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single channel copy.
    d_src = '{2, 0}; d_dst = '{5, 0}; d_len = '{4, 0}; d_rem = '{1, 0};
    run_round();
    // Zero-length transfer on ch1.
    d_src = '{0, 0}; d_dst = '{0, 0}; d_len = '{0, 0}; d_rem = '{0, 1};
    run_round();
    // Address wrap on both sides.
    d_src = '{14, 0}; d_dst = '{15, 0}; d_len = '{3, 0}; d_rem = '{1, 0};
    run_round();

    reset_mid_run();

    // Contention straight after reset: 0,1,0,1.
    d_src = '{0, 4}; d_dst = '{10, 12}; d_len = '{2, 2}; d_rem = '{2, 2};
    run_round();
    // Held req with no competitor: ch0 twice.
    d_src = '{7, 0}; d_dst = '{0, 0}; d_len = '{3, 0}; d_rem = '{2, 0};
    run_round();

    for (int r = 0; r < 30; r++) begin
      int any;
      any = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        d_rem[c] = ($urandom_range(0, 2) != 0) ? int'($urandom_range(1, 3)) : 0;
        if (d_rem[c] > 0) any = 1;
        d_src[c] = int'($urandom_range(0, DEPTH - 1));
        d_dst[c] = int'($urandom_range(0, DEPTH - 1));
        d_len[c] = int'($urandom_range(0, 31));
      end
      if (any == 0) d_rem[$urandom_range(0, NUM_CH - 1)] = 1;
      run_round();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Multi-channel DMA controller that sequences ROM-to-RAM block copies for NUM_CH requesters.
- Round-robin arbitration picks one channel at a time and latches its descriptor (src, dst, len).
- Generates ROM read addresses, absorbs the 1-cycle synchronous ROM latency, issues RAM writes, and pulses a per-channel done.
- Sits between the requesting engines and the shared ROM/RAM pair.

Parameters:
- DATA_WIDTH, 8: ROM/RAM data width.
- DEPTH, 16: ROM and RAM word count; all addresses wrap modulo DEPTH.
- NUM_CH, 2: number of requesting channels, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH): localparam, address width.
- LEN_WIDTH, ADDR_WIDTH+1: localparam, transfer length width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_CH  per-channel transfer request, level
- src_addr  in  NUM_CH x ADDR_WIDTH  per-channel ROM base address
- dst_addr  in  NUM_CH x ADDR_WIDTH  per-channel RAM base address
- len  in  NUM_CH x LEN_WIDTH  per-channel word count
- done  out  NUM_CH  one-cycle completion pulse, one-hot
- busy  out  1  high whenever the controller is not in IDLE
- grant_id  out  $clog2(NUM_CH)  channel currently being served
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM read data, valid the cycle after rom_en
- ram_wea  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM write address
- ram_data  out  DATA_WIDTH  RAM write data

Behaviour:
- Reset: state=IDLE; done=0, busy=0, grant_id=0, rom_en=0, rom_addr=0, ram_wea=0, ram_addr=0; RR pointer set so channel 0 has top priority.
- Reset mid-transfer aborts immediately. No done pulse; no further ROM/RAM activity.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - If any req is high, grant the first requester at or after (last_grant+1) mod NUM_CH.
  - Latch its src, dst, len; set grant_id; update last_grant.
  - Next state RUN if len!=0, else DONE.
  - req is sampled only in IDLE.
- RUN: cycle k (k=1..len) drives rom_en=1, rom_addr=(src+k-1) mod DEPTH. After cycle len, go to FLUSH.
- Write path:
  - rd_valid is a 1-cycle delay of rom_en; wr_addr is a register.
  - ram_wea=rd_valid, ram_addr=wr_addr, ram_data=rom_data (combinational passthrough).
  - Read k is written in cycle k+1 to (dst+k-1) mod DEPTH.
- FLUSH: rom_en=0; performs the final write (the one for read len); next state DONE.
- DONE: done[grant_id]=1 for exactly one cycle; next state IDLE.
- Requester protocol:
  - Hold req, src_addr, dst_addr, len stable from assertion until done.
  - Drop req by the clock edge that ends the done cycle; otherwise the channel is re-granted.
- Timing for len=N: first rom_en in the cycle after the grant edge; N writes on consecutive cycles; done N+2 cycles after the grant edge. For len=0, done comes 1 cycle after the grant edge with no ROM/RAM activity.
- Lengths greater than DEPTH are honoured exactly; addresses wrap and later writes overwrite earlier ones.
- busy=1 in RUN, FLUSH and DONE.
- Simultaneous requests: strict round robin, so no channel is granted twice while another is waiting.
- A channel whose req rises during a transfer waits for IDLE.

Decomposition:
- dma_pkg holds dma_state_e (IDLE/RUN/FLUSH/DONE) and a descriptor struct {src, dst, len} parameterised through localparams.
- One sub-module, rr_arbiter: req vector plus last_grant in, grant_valid and grant index out. Purely combinational; the pointer register stays in dma_ctrl.

Test Plan:
- Single channel: ch0 src=2, dst=5, len=4, ROM[i]=i+0x10. Required: RAM[5..8]=0x12..0x15, ram_wea high for 4 consecutive cycles, done[0] 6 cycles after the grant edge, busy low after.
- Zero length: ch1 len=0. Required: done[1] 1 cycle after the grant edge; rom_en and ram_wea never asserted.
- Wrap: src=14, dst=15, len=3, DEPTH=16. Required: reads at addresses 14, 15, 0; writes at addresses 15, 0, 1 with the matching data.
- Contention: ch0 and ch1 both request from reset, each len=2, each re-requesting after its done. Required grant order 0, 1, 0, 1, and never two consecutive grants to the same channel.
- Reset mid-RUN: assert reset in the 2nd RUN cycle of a len=8 transfer. Required: next cycle all outputs 0 and state IDLE; no done; the following request restarts cleanly with ch0 priority.
- Held req: keep req[0] high through its done. Required: ch0 re-granted at the next IDLE cycle, since no other requester is pending.
